// File: rtl/population_monitor.sv
// Per-generation statistics for the life_logic write stream: population, generation
// count, extinction and stability flags, published a fixed 4 cycles after done.
module population_monitor #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 20,
    parameter int STABLE_GENS = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic                   wr_en_in,
    input  logic [DATA_WIDTH-1:0]  data_w_in,
    input  logic                   done_in,
    output logic [COUNT_WIDTH-1:0] population_out,
    output logic [15:0]            generation_out,
    output logic                   pop_valid_out,
    output logic                   extinct_out,
    output logic                   stable_out
);
    localparam int PC_W  = $clog2(DATA_WIDTH + 1);
    // Sum is wide enough for either operand plus a carry, so saturation is exact
    // even when a single word's popcount exceeds the accumulator range.
    localparam int SUM_W = ((COUNT_WIDTH > PC_W) ? COUNT_WIDTH : PC_W) + 1;
    localparam logic [COUNT_WIDTH-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, PUBLISH} state_t;

    state_t                 state_q, state_d;
    logic                   drain_q, drain_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    logic [31:0]            sig_q, sig_d;
    logic [PC_W-1:0]        s1_cnt_q, s1_cnt_d;
    logic                   s1_vld_q, s1_vld_d;

    logic [COUNT_WIDTH-1:0] pop_q, prev_pop_q;
    logic [31:0]            prev_sig_q;
    logic [15:0]            gen_q;
    logic                   pv_q, ext_q, stable_q;
    logic [3:0]             stab_cnt_q, stab_cnt_d;

    logic                   counted_write;
    logic [PC_W-1:0]        word_pop;
    logic [SUM_W-1:0]       acc_sum;
    logic [31:0]            data_ext;

    assign counted_write = (state_q == ACCUM) && wr_en_in && !start_in;
    assign data_ext      = 32'(data_w_in);
    assign acc_sum       = SUM_W'(acc_q) + SUM_W'(s1_cnt_q);

    always_comb begin
        word_pop = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            word_pop = word_pop + PC_W'(data_w_in[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        acc_d    = acc_q;
        sig_d    = sig_q;
        s1_cnt_d = word_pop;
        s1_vld_d = counted_write;

        if (s1_vld_q) begin
            acc_d = (acc_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : acc_sum[COUNT_WIDTH-1:0];
        end
        if (counted_write) begin
            sig_d = {sig_q[30:0], sig_q[31]} ^ data_ext;
        end

        case (state_q)
            IDLE: begin
                if (start_in) state_d = ACCUM;
            end
            ACCUM: begin
                if (!start_in && done_in) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                if (start_in)      state_d = ACCUM;
                else if (drain_q)  state_d = PUBLISH;
                else               drain_d = 1'b1;
            end
            PUBLISH: begin
                state_d = start_in ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // start always opens a fresh generation; a publish in flight still reads acc_q
        if (start_in) begin
            acc_d    = '0;
            sig_d    = '0;
            s1_vld_d = 1'b0;
        end
    end

    always_comb begin
        stab_cnt_d = 4'd0;
        if (acc_q == prev_pop_q && sig_q == prev_sig_q) begin
            stab_cnt_d = (stab_cnt_q >= 4'(STABLE_GENS)) ? 4'(STABLE_GENS) : stab_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            drain_q    <= 1'b0;
            acc_q      <= '0;
            sig_q      <= '0;
            s1_cnt_q   <= '0;
            s1_vld_q   <= 1'b0;
            pop_q      <= '0;
            prev_pop_q <= '0;
            prev_sig_q <= '0;
            gen_q      <= '0;
            pv_q       <= 1'b0;
            ext_q      <= 1'b0;
            stable_q   <= 1'b0;
            stab_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            acc_q    <= acc_d;
            sig_q    <= sig_d;
            s1_cnt_q <= s1_cnt_d;
            s1_vld_q <= s1_vld_d;
            pv_q     <= (state_q == PUBLISH);
            if (state_q == PUBLISH) begin
                pop_q      <= acc_q;
                gen_q      <= gen_q + 16'd1;
                ext_q      <= (acc_q == '0);
                stab_cnt_q <= stab_cnt_d;
                stable_q   <= (stab_cnt_d >= 4'(STABLE_GENS));
                prev_pop_q <= acc_q;
                prev_sig_q <= sig_q;
            end
        end
    end

    assign population_out = pop_q;
    assign generation_out = gen_q;
    assign pop_valid_out  = pv_q;
    assign extinct_out    = ext_q;
    assign stable_out     = stable_q;
endmodule

// File: doc/population_monitor.md
# population_monitor

Generation statistics stage sitting directly downstream of `life_logic` on its buffer write port. It snoops every cell word `life_logic` writes during a generation, counts live cells through a two-stage popcount/accumulate pipeline, and publishes the per-generation population, a generation counter, and extinction and stability flags once `life_logic` reports done. Its outputs drive LEDs and the seven-segment display. It never back-pressures `life_logic` or `double_buffer`.

## Interface
- `DATA_WIDTH`, 16: bits per cell word (width of `data_t`); each bit is one cell, 1 = alive.
- `COUNT_WIDTH`, 20: population accumulator width.
- `STABLE_GENS`, 4: consecutive unchanged generations required to assert `stable_out`; valid range 1..15.
- Clocking (already decided): one clock, `clk_in`; reset `rst_in` is synchronous and active-high.
- `clk_in`  in  1  100 MHz system clock (same as `life_logic`).
- `rst_in`  in  1  synchronous active-high reset.
- `start_in`  in  1  one-cycle pulse; generation begins (same signal as `life_logic` start).
- `wr_en_in`  in  1  `life_logic` write strobe.
- `data_w_in`  in  DATA_WIDTH  word being written.
- `done_in`  in  1  `life_logic` done level/pulse; rising edge not required, sampled level.
- `population_out`  out  COUNT_WIDTH  live cells in the last completed generation.
- `generation_out`  out  16  completed-generation count, wraps 0xFFFF→0.
- `pop_valid_out`  out  1  one-cycle pulse when outputs update.
- `extinct_out`  out  1  last published population == 0.
- `stable_out`  out  1  population and signature unchanged for STABLE_GENS consecutive publishes.

## Operation
- FSM states: IDLE, ACCUM, DRAIN, PUBLISH.
  - IDLE: `start_in` → clear the accumulator, the signature, and the pipeline valid bits; go to ACCUM.
  - ACCUM: count writes; `done_in`=1 → DRAIN.
  - DRAIN: 2 cycles, so that writes up to and including the done cycle finish the pipeline; then PUBLISH.
  - PUBLISH: 1 cycle; update the outputs; go to IDLE.
- Pipeline:
  - Stage 1 registers popcount(`data_w_in`) together with a valid bit, set when `wr_en_in`=1 in ACCUM.
  - Stage 2 adds the stage-1 count into the accumulator.
  - The accumulator saturates at 2^COUNT_WIDTH−1 and does not wrap.
- Signature: a 32-bit register. On each counted write: sig ← rotl(sig,1) XOR zero-extended `data_w_in`. The signature is order-sensitive.
- PUBLISH updates:
  - `population_out` ← accumulator; `generation_out` += 1; `extinct_out` ← (accumulator==0).
  - If accumulator == previous population and sig == previous sig, stable counter += 1, saturating at STABLE_GENS. Otherwise the stable counter ← 0.
  - `stable_out` ← (new counter ≥ STABLE_GENS); previous population/sig ← current.
- `wr_en_in` outside ACCUM (cursor-click edits, post-done writes) is ignored.
- `done_in` outside ACCUM is ignored.
- `start_in` in ACCUM, DRAIN or PUBLISH aborts the current generation:
  - accumulator, signature, and pipeline are cleared; the FSM goes to ACCUM;
  - nothing is published and `generation_out` is unchanged.
  - Exception: `start_in` during PUBLISH still completes the publish, then enters ACCUM next cycle.
- `wr_en_in` and `done_in` in the same ACCUM cycle: the write is counted.

## Timing
- Reset values: `population_out`=0, `generation_out`=0, `pop_valid_out`=0, `extinct_out`=0, `stable_out`=0; state IDLE; previous population=0; previous sig=0; stable counter=0.
- `rst_in` mid-generation: the next cycle is IDLE with all outputs at their reset values. There is no partial publish.
- Write latency: a write in cycle t is in the accumulator after edge t+2.
- `done_in` sampled in cycle d: DRAIN in cycles d+1 and d+2, PUBLISH in d+3, and new outputs visible from cycle d+4. `pop_valid_out`=1 only in cycle d+4.
- `start_in` back-to-back with the previous publish is accepted with no dead cycle.

## Test plan
- Reset, then `start_in`, then writes 0xFFFF, 0x0001, 0x8000, then `done_in` → `population_out`=18, `generation_out`=1, a single `pop_valid_out` pulse 4 cycles after done, `extinct_out`=0.
- A generation with writes all 0x0000 → `population_out`=0 and `extinct_out`=1. The following generation with one 0x0010 write clears `extinct_out`.
- Five identical generations (writes 0x0F0F, 0x00F0) with STABLE_GENS=4 → `stable_out` rises at the 5th publish. A sixth generation with the words swapped keeps population=12 but changes the signature → `stable_out`=0.
- Writes asserted in IDLE and after done, plus `wr_en_in` together with `done_in` in the same cycle → only ACCUM writes, including the coincident one, are counted.
- `start_in` reasserted mid-ACCUM after 3 writes → those writes are discarded and `generation_out` is unchanged. `rst_in` during DRAIN → no pulse and all outputs 0.
- COUNT_WIDTH=4 with two 0xFFFF writes → `population_out`=15 (saturated).
